kernel_ascii_rx: RTL
====================

KERNEL_ASCII_RX -- requirements
Module: kernel_ascii_rx

Interface
REQ-001 Parameter N_VALUES, default 9: number of kernel entries to collect (legal range 1..25).
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000: maximum idle cycles between received bytes while busy; 0 disables the timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle strobe; arms a new kernel capture.
REQ-006 rx_valid  input  1  single-cycle strobe from the UART receiver; rx_data valid this cycle.
REQ-007 rx_data  input  8  received ASCII byte.
REQ-008 kernel_flat  output  200  packed kernel; entry k at bits [8k+7:8k].
REQ-009 busy  output  1  high while a capture is in progress.
REQ-010 done  output  1  one-cycle pulse on successful capture.
REQ-011 error  output  1  sticky failure flag.
REQ-012 err_code  output  2  0 none, 1 illegal character, 2 value overflow, 3 timeout.
REQ-013 value_count  output  5  number of entries committed in the current capture.

Function
REQ-014 States: IDLE, SEP (waiting for first digit of a number), NUM (accumulating digits), FAIL.
REQ-015 IDLE: start -> SEP; busy=1; error=0; err_code=0; value_count=0; accumulator=0; shadow buffer cleared to 0; rx_valid is ignored.
REQ-016 Digit bytes 0x30..0x39 in SEP or NUM: acc <= acc*10 + (byte-0x30); state -> NUM; leading zeros accepted ("007" = 7).
REQ-017 Overflow: if acc*10+digit > 255 -> FAIL with err_code=2; internal arithmetic is at least 12 bits wide so the compare is exact.
REQ-018 Separator bytes 0x20, 0x2C, 0x09, 0x0D, 0x0A: in SEP, ignored (repeated separators allowed); in NUM, commit acc to shadow entry value_count, value_count+1, acc <= 0, state -> SEP.
REQ-019 The commit of entry N_VALUES-1 additionally copies the shadow buffer into kernel_flat, pulses done for 1 cycle, drops busy, and returns to IDLE in the same edge.
REQ-020 kernel_flat changes only on a completed capture (atomic update); it holds its previous value during capture and after FAIL.
REQ-021 Entries at index >= N_VALUES SHALL be 0 in kernel_flat.
REQ-022 Any other byte in SEP or NUM -> FAIL with err_code=1; ESC (0x1B) is treated as illegal (abort).
REQ-023 Timeout: counter resets on start and on every rx_valid; when it reaches TIMEOUT_CYCLES while busy -> FAIL with err_code=3.
REQ-024 FAIL: busy=0, error=1, err_code held; rx_valid ignored; start -> SEP with error cleared, as in REQ-015.
REQ-025 Start while busy restarts the capture (REQ-015 actions); a byte arriving in the same cycle as start is dropped.
REQ-026 Latency: each byte is fully processed in the cycle rx_valid is high; back-to-back rx_valid on consecutive cycles is supported.
REQ-027 value_count saturates at N_VALUES; it holds its final value in IDLE/FAIL until the next start.

Reset
REQ-028 rst (synchronous, at any state including mid-capture): state=IDLE, kernel_flat=0, busy=0, done=0, error=0, err_code=0, value_count=0, accumulator=0, timeout counter=0.

Verification
REQ-029 start, then send "1 2 3 4 5 6 7 8 9\n" -> done pulses once after the last '\n'; kernel_flat[71:0]=0x090807060504030201; bits [199:72]=0; busy=0.
REQ-030 start, then send "255,0,,  12\r\n" with N_VALUES=3 -> kernel_flat[23:0]=0x0C00FF; value_count=3; error=0.
REQ-031 start, then send "25" followed by "6" -> FAIL, err_code=2, kernel_flat unchanged from its prior value.
REQ-032 start, then send "3 x" -> FAIL, err_code=1 on the 'x' cycle; a new start followed by a valid stream -> done, error=0.
REQ-033 TIMEOUT_CYCLES=50: start, send "4 ", then idle 50 cycles -> error=1, err_code=3, busy=0.
REQ-034 Mid-capture: rst after "1 2 " -> all outputs 0; start asserted coincident with rx_valid='7' -> byte dropped, value_count=0.

Source files
------------

// File: rtl/kernel_ascii_rx.sv
// Receives a kernel as ASCII decimal numbers from a UART byte stream. Each number is
// range-checked as it arrives and committed into a shadow buffer that is published atomically.
module kernel_ascii_rx #(
  parameter int unsigned N_VALUES       = 9,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [199:0] kernel_flat,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   err_code,
  output logic [4:0]   value_count
);

  localparam int unsigned MAX_VALUES = 25;
  localparam int unsigned KW         = 8 * MAX_VALUES;
  localparam int unsigned ACC_W      = 12;
  localparam int unsigned TMO_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TMO     = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SEP, S_NUM, S_FAIL} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [KW-1:0]     shadow_q, shadow_d;
  logic [KW-1:0]     kernel_q, kernel_d;
  logic [4:0]        value_count_q, value_count_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              is_digit, is_sep, capturing, byte_fire;
  logic              last_entry, tmo_hit, commit, fail_ev;
  logic [ACC_W-1:0]  acc_calc;
  logic [1:0]        fail_code;

  // Byte classification and event decode shared by the next-state and output logic.
  always_comb begin
    is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_sep     = (rx_data == 8'h20) || (rx_data == 8'h2C) || (rx_data == 8'h09) ||
                 (rx_data == 8'h0D) || (rx_data == 8'h0A);
    capturing  = (state_q == S_SEP) || (state_q == S_NUM);
    byte_fire  = capturing && rx_valid && !start;
    acc_calc   = acc_q * ACC_W'(10) + ACC_W'(rx_data[3:0]);
    last_entry = (32'(value_count_q) == (N_VALUES - 32'd1));
    tmo_hit    = (TIMEOUT_CYCLES != 0) && capturing && !rx_valid && !start &&
                 ((32'(tmo_q) + 32'd1) >= TIMEOUT_CYCLES);
    commit     = byte_fire && is_sep && (state_q == S_NUM);
    fail_code  = ERR_NONE;
    if (byte_fire) begin
      if (is_digit) begin
        if (acc_calc > ACC_W'(255)) fail_code = ERR_OVF;
      end else if (!is_sep) begin
        fail_code = ERR_ILLEGAL;
      end
    end else if (tmo_hit) begin
      fail_code = ERR_TMO;
    end
    fail_ev = (fail_code != ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)                      state_d = S_SEP;
    else if (fail_ev)               state_d = S_FAIL;
    else if (commit)                state_d = last_entry ? S_IDLE : S_SEP;
    else if (byte_fire && is_digit) state_d = S_NUM;
  end

  // Datapath and output register next-values.
  always_comb begin
    acc_d         = acc_q;
    shadow_d      = shadow_q;
    kernel_d      = kernel_q;
    value_count_d = value_count_q;
    tmo_d         = tmo_q;
    error_d       = error_q;
    err_code_d    = err_code_q;
    done_d        = 1'b0;
    busy_d        = (state_d == S_SEP) || (state_d == S_NUM);
    if (start) begin
      acc_d         = '0;
      shadow_d      = '0;
      value_count_d = '0;
      tmo_d         = '0;
      error_d       = 1'b0;
      err_code_d    = ERR_NONE;
    end else if (capturing) begin
      tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
      if (fail_ev) begin
        error_d    = 1'b1;
        err_code_d = fail_code;
      end else if (commit) begin
        for (int k = 0; k < MAX_VALUES; k++) begin
          if (5'(k) == value_count_q) shadow_d[8*k +: 8] = acc_q[7:0];
        end
        acc_d         = '0;
        value_count_d = value_count_q + 5'd1;
        if (last_entry) begin
          kernel_d = shadow_d;
          done_d   = 1'b1;
        end
      end else if (byte_fire && is_digit) begin
        acc_d = acc_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      shadow_q      <= '0;
      kernel_q      <= '0;
      value_count_q <= '0;
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      acc_q         <= acc_d;
      shadow_q      <= shadow_d;
      kernel_q      <= kernel_d;
      value_count_q <= value_count_d;
      tmo_q         <= tmo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign kernel_flat = kernel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign value_count = value_count_q;

endmodule
